// File: rtl/prim_clock_gating_ctrl.sv
// Multi-channel clock-gating controller: per-channel wake-latency / idle hold-off FSM
// driving one latch-based clock gate per channel, with a ready acknowledge per consumer.
module prim_clock_gating_ctrl #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned WAKE_LAT    = 2,
   parameter int unsigned HOLD_CYCLES = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              test_en_i,
   output logic [NUM_CH-1:0] clk_o,
   output logic [NUM_CH-1:0] ack_o,
   output logic [NUM_CH-1:0] en_o,
   output logic              busy_o
);

   localparam logic [1:0] ST_GATED = 2'd0;
   localparam logic [1:0] ST_WAKE  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [7:0] WAKE_INIT = (WAKE_LAT    > 0) ? 8'(WAKE_LAT - 1)    : '0;
   localparam logic [7:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : '0;

   logic [1:0] state_q [NUM_CH];
   logic [1:0] state_d [NUM_CH];
   logic [7:0] cnt_q   [NUM_CH];
   logic [7:0] cnt_d   [NUM_CH];

   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         case (state_q[c])
            ST_GATED: begin
               if (req_i[c]) begin
                  if (WAKE_LAT == 0) begin
                     state_d[c] = ST_RUN;
                  end else begin
                     state_d[c] = ST_WAKE;
                     cnt_d[c]   = WAKE_INIT;
                  end
               end
            end
            // request is deliberately ignored while waking; wake always completes
            ST_WAKE: begin
               if (cnt_q[c] != '0) cnt_d[c]   = cnt_q[c] - 8'd1;
               else                state_d[c] = ST_RUN;
            end
            ST_RUN: begin
               if (!req_i[c]) begin
                  if (HOLD_CYCLES == 0) begin
                     state_d[c] = ST_GATED;
                  end else begin
                     state_d[c] = ST_DRAIN;
                     cnt_d[c]   = HOLD_INIT;
                  end
               end
            end
            default: begin
               if (req_i[c])            state_d[c] = ST_RUN;
               else if (cnt_q[c] != '0) cnt_d[c]   = cnt_q[c] - 8'd1;
               else                     state_d[c] = ST_GATED;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (rst_i) begin
            state_q[c] <= ST_GATED;
            cnt_q[c]   <= '0;
         end else begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign en_o[c]  = (state_q[c] != ST_GATED);
      assign ack_o[c] = (state_q[c] == ST_RUN) || (state_q[c] == ST_DRAIN);

      OPENROAD_CLKGATE u_cg (
         .CK  (clk_i),
         .E   (en_o[c] | test_en_i),
         .GCK (clk_o[c])
      );
   end

   assign busy_o = |en_o;

endmodule

// Behavioural model of the latch-based integrated clock gate.
module OPENROAD_CLKGATE (
   input  logic CK,
   input  logic E,
   output logic GCK
);

   logic en_l;

   always_latch begin
      if (!CK) en_l <= E;
   end

   assign GCK = CK & en_l;

endmodule

// File: tb/tb_prim_clock_gating_ctrl.sv
// Directed bench for prim_clock_gating_ctrl: three configurations share one clock.
module tb_prim_clock_gating_ctrl;

   logic       clk;
   logic       rst;
   logic       test_en;
   logic [3:0] req_a, clk_a, ack_a, en_a;
   logic       busy_a;
   logic [0:0] req_b, clk_b, ack_b, en_b;
   logic       busy_b;
   logic [0:0] req_c, clk_c, ack_c, en_c;
   logic       busy_c;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   prim_clock_gating_ctrl #(.NUM_CH(4), .WAKE_LAT(2), .HOLD_CYCLES(8)) u_a (
      .clk_i(clk), .rst_i(rst), .req_i(req_a), .test_en_i(test_en),
      .clk_o(clk_a), .ack_o(ack_a), .en_o(en_a), .busy_o(busy_a));

   prim_clock_gating_ctrl #(.NUM_CH(1), .WAKE_LAT(0), .HOLD_CYCLES(0)) u_b (
      .clk_i(clk), .rst_i(rst), .req_i(req_b), .test_en_i(test_en),
      .clk_o(clk_b), .ack_o(ack_b), .en_o(en_b), .busy_o(busy_b));

   prim_clock_gating_ctrl #(.NUM_CH(1), .WAKE_LAT(2), .HOLD_CYCLES(0)) u_c (
      .clk_i(clk), .rst_i(rst), .req_i(req_c), .test_en_i(test_en),
      .clk_o(clk_c), .ack_o(ack_c), .en_o(en_c), .busy_o(busy_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance n rising edges; returns at the following falling edge.
   task automatic step(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] pat;
      rst     = 1'b1;
      test_en = 1'b0;
      req_a   = '0;
      req_b   = '0;
      req_c   = '0;

      // reset / idle
      step(3);
      chk("rst_en_a",   32'(en_a),   32'h0);
      chk("rst_ack_a",  32'(ack_a),  32'h0);
      chk("rst_busy_a", 32'(busy_a), 32'h0);
      chk("rst_en_b",   32'(en_b),   32'h0);
      chk("rst_en_c",   32'(en_c),   32'h0);
      @(posedge clk); #1;
      chk("rst_clk_a_high", 32'(clk_a), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // wake channel 0 (WAKE_LAT=2)
      req_a[0] = 1'b1;
      step(1);
      chk("wake_en_E",   32'(en_a),   32'h1);
      chk("wake_ack_E",  32'(ack_a),  32'h0);
      chk("wake_busy_E", 32'(busy_a), 32'h1);
      @(posedge clk); #1;
      chk("wake_clk_pulse", 32'(clk_a), 32'h1);
      @(negedge clk);
      chk("wake_ack_E1", 32'(ack_a), 32'h0);
      step(1);
      chk("wake_ack_E2", 32'(ack_a), 32'h1);
      chk("wake_en_E2",  32'(en_a),  32'h1);

      // hold-off on channel 1, full drain
      req_a[1] = 1'b1;
      step(3);
      chk("hold_run_ack1", 32'(ack_a[1]), 32'h1);
      req_a[1] = 1'b0;
      step(8);
      chk("hold_F7_ack1", 32'(ack_a[1]), 32'h1);
      chk("hold_F7_en1",  32'(en_a[1]),  32'h1);
      step(1);
      chk("hold_F8_ack1", 32'(ack_a[1]), 32'h0);
      chk("hold_F8_en1",  32'(en_a[1]),  32'h0);
      chk("hold_F8_ack0", 32'(ack_a[0]), 32'h1);

      // hold-off interrupted by re-request: ack must never drop
      req_a[1] = 1'b1;
      step(3);
      req_a[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("rereq_drain_ack1", 32'(ack_a[1]), 32'h1);
      end
      req_a[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("rereq_run_ack1", 32'(ack_a[1]), 32'h1);
      end

      // drop during wake (WAKE_LAT=2, HOLD_CYCLES=0)
      req_c = 1'b1;
      step(1);
      req_c = 1'b0;
      chk("dwake_en_E",   32'(en_c),  32'h1);
      chk("dwake_ack_E",  32'(ack_c), 32'h0);
      step(1);
      chk("dwake_en_E1",  32'(en_c),  32'h1);
      chk("dwake_ack_E1", 32'(ack_c), 32'h0);
      step(1);
      chk("dwake_en_E2",  32'(en_c),  32'h1);
      chk("dwake_ack_E2", 32'(ack_c), 32'h1);
      step(1);
      chk("dwake_en_E3",  32'(en_c),  32'h0);
      chk("dwake_ack_E3", 32'(ack_c), 32'h0);

      // zero-latency config: en/ack follow req one edge later
      pat = 8'b0010_1101;
      for (int i = 0; i < 8; i++) begin
         req_b = pat[i];
         step(1);
         chk("zl_en",  32'(en_b),  32'(pat[i]));
         chk("zl_ack", 32'(ack_b), 32'(pat[i]));
      end
      req_b = 1'b0;

      // test mode: all gates open, FSM unaffected
      test_en = 1'b1;
      step(1);
      @(posedge clk); #1;
      chk("test_clk_all", 32'(clk_a),   32'hF);
      chk("test_en2",     32'(en_a[2]), 32'h0);
      chk("test_clk_b",   32'(clk_b),   32'h1);
      @(negedge clk); #1;
      chk("test_clk_low", 32'(clk_a), 32'h0);
      test_en = 1'b0;
      step(1);
      @(posedge clk); #1;
      chk("test_off_clk", 32'(clk_a), 32'h3);

      // reset while channel 3 drains
      @(negedge clk);
      req_a[3] = 1'b1;
      step(3);
      req_a[3] = 1'b0;
      step(2);
      chk("drain_ack3", 32'(ack_a[3]), 32'h1);
      rst = 1'b1;
      step(1);
      chk("rstmid_ack3", 32'(ack_a[3]), 32'h0);
      chk("rstmid_en3",  32'(en_a[3]),  32'h0);
      chk("rstmid_en",   32'(en_a),     32'h0);
      chk("rstmid_busy", 32'(busy_a),   32'h0);
      rst = 1'b0;
      req_a = '0;
      step(1);
      chk("post_rst_en", 32'(en_a), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
